// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 mux: walks the select through the enabled channels,
// samples the mux output at the end of each dwell and publishes 8-bit frames.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 20,
  parameter int unsigned CW    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic [7:0] mask,
  input  logic       mux_o,
  output logic [2:0] sel,
  output logic [7:0] sample,
  output logic       valid,
  output logic       busy
);

  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DWELL,
    S_LAST
  } state_t;

  state_t        state;
  logic [7:0]    mask_q;
  logic [7:0]    shadow;
  logic [CW-1:0] cnt;

  logic [2:0]    first_sel;
  logic [2:0]    next_sel;
  logic          has_next;
  logic          mask_any;

  // Lowest enabled channel of the live mask (used when a frame is launched).
  always_comb begin
    first_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) first_sel = 3'(i);
    end
  end

  assign mask_any = |mask;

  // Next enabled channel strictly above the current select in the latched mask.
  always_comb begin
    next_sel = sel;
    has_next = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (3'(i) > sel)) begin
        next_sel = 3'(i);
        has_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mask_q <= 8'h00;
      shadow <= 8'h00;
      cnt    <= '0;
      sel    <= 3'd0;
      sample <= 8'h00;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && mask_any) begin
            mask_q <= mask;
            shadow <= 8'h00;
            sel    <= first_sel;
            cnt    <= DWELL_LOAD;
            busy   <= 1'b1;
            state  <= S_DWELL;
          end
        end

        S_DWELL: begin
          if (cnt == '0) begin
            shadow[sel] <= mux_o;
            if (has_next) begin
              sel <= next_sel;
              cnt <= DWELL_LOAD;
            end else begin
              state <= S_LAST;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        S_LAST: begin
          sample <= shadow;
          valid  <= 1'b1;
          // Back-to-back frame: relaunch on the same edge that publishes the sample.
          if (cont && mask_any) begin
            mask_q <= mask;
            shadow <= 8'h00;
            sel    <= first_sel;
            cnt    <= DWELL_LOAD;
            state  <= S_DWELL;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed self-checking bench for mux_scan_ctrl (DWELL=20) with a behavioural 8:1 mux.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cont;
  logic [7:0] mask;
  logic       mux_o;
  logic [2:0] sel;
  logic [7:0] sample;
  logic       valid;
  logic       busy;

  logic [7:0] inputs;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  int unsigned vcount   = 0;
  int unsigned sel_bad  = 0;
  int unsigned k        = 0;
  logic [2:0]  seq [8];
  logic        got;
  logic [7:0]  exp_samp [3];
  logic [7:0]  nxt_in   [3];

  mux_scan_ctrl #(.DWELL(20), .CW(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cont   (cont),
    .mask   (mask),
    .mux_o  (mux_o),
    .sel    (sel),
    .sample (sample),
    .valid  (valid),
    .busy   (busy)
  );

  assign mux_o = inputs[sel];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel visit order for a given mask, lowest index first.
  task automatic set_frame(input logic [7:0] m);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      seq[i] = 3'd0;
    end
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        seq[k] = 3'(i);
        k++;
      end
    end
  endtask

  task automatic step();
    logic [2:0] exp_sel;
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      vcount++;
    end else begin
      exp_sel = (cyc < k * 20) ? seq[cyc / 20] : seq[k - 1];
      if (sel !== exp_sel) sel_bad++;
    end
  endtask

  task automatic wait_valid(input int unsigned limit, output logic seen);
    int unsigned v0;
    v0   = vcount;
    seen = 1'b0;
    while (!seen && cyc < limit) begin
      step();
      if (vcount != v0) seen = 1'b1;
    end
  endtask

  task automatic launch();
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    cyc     = 0;
    vcount  = 0;
    sel_bad = 0;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    cont   = 1'b0;
    mask   = 8'h00;
    inputs = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_sample", 32'(sample), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // One-shot, full mask
    inputs = 8'h4D;
    mask   = 8'hFF;
    set_frame(8'hFF);
    launch();
    check("t1_busy_start", 32'(busy), 32'd1);
    check("t1_sel_start", 32'(sel), 32'd0);
    wait_valid(200, got);
    check("t1_latency", cyc, 32'd161);
    check("t1_sample", 32'(sample), 32'h4D);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_sel_seq", sel_bad, 32'd0);
    step();
    check("t1_valid_1cyc", 32'(valid), 32'd0);
    check("t1_sel_hold", 32'(sel), 32'd7);
    check("t1_sample_hold", 32'(sample), 32'h4D);

    // Sparse mask with a start pulse while busy
    inputs = 8'hFF;
    mask   = 8'hA4;
    set_frame(8'hA4);
    launch();
    check("t2_sel_start", 32'(sel), 32'd2);
    repeat (30) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(100, got);
    check("t2_latency", cyc, 32'd61);
    check("t2_sample", 32'(sample), 32'hA4);
    repeat (10) step();
    check("t2_one_valid", vcount, 32'd1);
    check("t2_sel_seq", sel_bad, 32'd0);
    check("t2_sel_hold", 32'(sel), 32'd7);

    // Start with empty mask is ignored
    mask   = 8'h00;
    vcount = 0;
    start  = 1'b1;
    step();
    start = 1'b0;
    check("t3_busy", 32'(busy), 32'd0);
    repeat (20) step();
    check("t3_no_valid", vcount, 32'd0);
    check("t3_sel_hold", 32'(sel), 32'd7);

    // Continuous mode, three frames, cont dropped in the third
    exp_samp[0] = 8'h96; exp_samp[1] = 8'h3C; exp_samp[2] = 8'hE1;
    nxt_in[0]   = 8'h3C; nxt_in[1]   = 8'hE1; nxt_in[2]   = 8'h00;
    inputs = 8'h96;
    mask   = 8'hFF;
    cont   = 1'b1;
    set_frame(8'hFF);
    launch();
    for (int f = 0; f < 3; f++) begin
      if (f == 2) begin
        repeat (50) step();
        cont = 1'b0;
      end
      wait_valid(200, got);
      check($sformatf("t4_latency_f%0d", f), cyc, 32'd161);
      check($sformatf("t4_sample_f%0d", f), 32'(sample), 32'(exp_samp[f]));
      check($sformatf("t4_busy_f%0d", f), 32'(busy), (f < 2) ? 32'd1 : 32'd0);
      check($sformatf("t4_sel_seq_f%0d", f), sel_bad, 32'd0);
      if (f < 2) begin
        cyc     = 0;
        sel_bad = 0;
        inputs  = nxt_in[f];
      end
    end
    repeat (20) step();
    check("t4_valid_count", vcount, 32'd3);
    check("t4_idle_busy", 32'(busy), 32'd0);

    // Mask change mid-frame only affects the next continuous frame
    inputs = 8'h5A;
    mask   = 8'hFF;
    cont   = 1'b1;
    set_frame(8'hFF);
    launch();
    repeat (65) step();
    check("t5_sel_at_change", 32'(sel), 32'd3);
    mask = 8'h01;
    wait_valid(200, got);
    check("t5_latency_a", cyc, 32'd161);
    check("t5_sample_a", 32'(sample), 32'h5A);
    check("t5_sel_seq_a", sel_bad, 32'd0);
    set_frame(8'h01);
    cyc     = 0;
    sel_bad = 0;
    inputs  = 8'hFF;
    check("t5_sel_restart", 32'(sel), 32'd0);
    repeat (5) step();
    cont = 1'b0;
    wait_valid(40, got);
    check("t5_latency_b", cyc, 32'd21);
    check("t5_sample_b", 32'(sample), 32'h01);
    check("t5_busy_b", 32'(busy), 32'd0);
    check("t5_sel_seq_b", sel_bad, 32'd0);

    // Asynchronous reset mid-dwell discards the frame
    inputs = 8'hFF;
    mask   = 8'hFF;
    set_frame(8'hFF);
    launch();
    repeat (45) step();
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_sel", 32'(sel), 32'd0);
    check("t6_rst_sample", 32'(sample), 32'h00);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_frame(8'h01);
    vcount  = 0;
    sel_bad = 0;
    repeat (200) step();
    check("t6_no_valid", vcount, 32'd0);
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_sel_idle", sel_bad, 32'd0);

    // Highest channel only
    inputs = 8'h80;
    mask   = 8'h80;
    set_frame(8'h80);
    launch();
    check("t7_sel_start", 32'(sel), 32'd7);
    wait_valid(40, got);
    check("t7_latency", cyc, 32'd21);
    check("t7_sample", 32'(sample), 32'h80);
    check("t7_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits around the 8:1 multiplexer: it drives the mux select and consumes the mux output.
- Steps the select through the enabled channels, holding each for a programmable dwell time so the mux output settles.
- Samples the 1-bit mux output at the end of each dwell and assembles an 8-bit frame.
- Presents the completed frame with a one-cycle valid pulse; supports one-shot and continuous scanning.

Parameters:
DWELL, 20, clock cycles each channel stays selected before its sample is taken (legal range 2..65535)
CW, 16, width of the internal dwell counter (must satisfy 2^CW > DWELL)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a scan; sampled on rising edge of clk
cont  input  1  1 = continuous scanning, 0 = one frame per start
mask  input  8  channel enable, bit i enables channel i
mux_o  input  1  output of the 8:1 mux (channel currently selected by sel)
sel  output  3  mux select
sample  output  8  last completed frame, bit i = value captured from channel i
valid  output  1  one-cycle pulse: sample updated this cycle
busy  output  1  high while a frame is in progress

Behaviour:
- Reset (rst_n low, asynchronous):
  - sel=0, sample=8'h00, valid=0, busy=0.
  - Internal shadow register=0, dwell counter=0, FSM=IDLE.
  - Release is handled synchronously; the first start is accepted on the first rising edge with rst_n high.
- States: IDLE, DWELL, LAST.
- IDLE:
  - busy=0; sel holds its last value.
  - Edge with start=1 and mask!=0:
    - latch mask into mask_q.
    - clear shadow.
    - sel <= lowest set bit of mask.
    - counter <= DWELL-1.
    - busy <= 1, go to DWELL.
  - start=1 with mask=0: ignored, stay IDLE, no valid.
- DWELL:
  - Counter decrements once per clock.
  - On the edge where counter==0, shadow[sel] <= mux_o.
  - If a higher-index channel is set in mask_q: sel <= next higher enabled index, counter <= DWELL-1, stay in DWELL.
  - Otherwise go to LAST.
- LAST (single cycle):
  - sample <= shadow; bit for the just-captured channel comes from the capture; disabled channels read 0.
  - valid <= 1 for exactly one cycle.
  - If cont=1 (value at this edge) and the live mask!=0: relatch mask, clear shadow, sel <= lowest enabled, counter <= DWELL-1, go to DWELL. busy stays 1.
  - Else: busy <= 0, go to IDLE.
- Timing:
  - start accepted at edge T: sel changes at T.
  - First capture at edge T+DWELL.
  - With k enabled channels, the last capture is at T+k·DWELL.
  - valid is high in the cycle after edge T+k·DWELL+1, i.e. frame latency is k·DWELL+1 cycles.
  - In continuous mode, the next frame's first sel change coincides with valid's edge.
- Mask and start handling:
  - mask changes mid-frame have no effect; the latched copy is used until the next frame start.
  - start while busy=1 is ignored (no restart, no queueing).
  - cont dropped mid-frame: the current frame completes, then IDLE.
- sel only ever takes values enabled in mask_q while busy=1, and only changes on dwell boundaries. Each select value is therefore held stable for exactly DWELL cycles.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded and no valid is issued.
- sample holds its value between valid pulses; it is never partially updated.

Test Plan:
- Reset → sel=0, sample=00, valid=0, busy=0. Assert rst_n=0 asynchronously mid-DWELL → outputs return to reset values without a clock edge; no valid follows.
- One-shot, full mask:
  - Stimulus: DWELL=20, mask=FF, cont=0; mux inputs I0..I7 = 1,0,1,1,0,0,1,0; start pulse at T.
  - Required response: sel steps 0..7, each held 20 cycles; valid single pulse at T+161; sample=8'h4D; busy falls with valid; sel stays 7.
- Sparse mask:
  - Stimulus: mask=8'b1010_0100, all mux inputs 1.
  - Required response: sel visits only 2,5,7; valid at T+61; sample=8'hA4 (disabled bits 0).
- Mask=0 start → no busy, no valid. Start pulsed while busy → frame timing unchanged, exactly one valid.
- Continuous mode:
  - Stimulus: cont=1, mask=FF, inputs toggled between frames.
  - Required response: valid every 161 cycles, each sample matching that frame's inputs.
  - Then clear cont mid-frame → that frame completes with valid, then busy=0.
- Mid-frame mask change:
  - Stimulus: change mask from FF to 01 while sel=3.
  - Required response: the current frame still visits 4..7; the next cont frame visits only channel 0 with valid 21 cycles later.
